// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and helpers for the register-sharing write arbiter.
// The state encoding, default sizing and one-hot helper live here.
package reg_share_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam int NREQ_MAX  = 8;
  localparam int NREQ_DEF  = 4;
  localparam int PTR_W_DEF = $clog2(NREQ_DEF);

  function automatic logic [NREQ_MAX-1:0] onehot(input int unsigned idx);
    return NREQ_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the arbiter: requests, data and grant, plus the
// shared register view returned to the requesters.
interface reg_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int PTR_W = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  q_vld;
  logic [PTR_W-1:0]      owner;
  logic                  busy;

  modport master (output req, lock, din, input gnt, q, q_vld, owner, busy);
  modport slave  (input req, lock, din, output gnt, q, q_vld, owner, busy);
endinterface

// File: rtl/reg_share_arbiter_rr_pick.sv
// Rotating-priority selector: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic             found
);

  logic [PTR_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter owning the single shared register; a granted requester
// may lock it for a bounded burst of back-to-back writes.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst_n,
  reg_share_arbiter_if.slave bus
);

  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]  xfer_idx;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              q_vld_q, q_vld_d;
  logic [NREQ-1:0]   pick_gnt, gnt;
  logic              pick_found;
  logic              xfer;

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  // Grant: locked owner only while in OWN, rotating pick otherwise; never during reset.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (state_q == OWN) begin
        gnt = bus.req[owner_q] ? NREQ'(onehot(32'(owner_q))) : '0;
      end else if (pick_found) begin
        gnt = pick_gnt;
      end
    end
  end

  always_comb begin
    xfer_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) xfer_idx = PTR_W'(i);
    end
  end

  assign xfer = |(bus.req & gnt);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hold_inc = hold_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (xfer && bus.lock[xfer_idx] && (MAX_HOLD > 1)) begin
          state_d = OWN;
          hold_d  = HOLD_W'(1);
        end
      end
      OWN: begin
        // In OWN a missing transfer can only mean the owner dropped req.
        if (!xfer || !bus.lock[owner_q] || (hold_inc == HOLD_W'(MAX_HOLD))) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d  = hold_inc;
        end
      end
    endcase
  end

  always_comb begin
    q_d     = q_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    q_vld_d = xfer;
    if (xfer) begin
      q_d     = bus.din[xfer_idx*WIDTH +: WIDTH];
      owner_d = xfer_idx;
      ptr_d   = (xfer_idx == PTR_W'(NREQ - 1)) ? '0 : xfer_idx + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      q_vld_q <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      q_q     <= q_d;
      q_vld_q <= q_vld_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt   = gnt;
  assign bus.q     = q_q;
  assign bus.q_vld = q_vld_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == OWN);

endmodule
